// File: rtl/key_pkg.sv
// Shared key-path definitions: FSM state encoding and the cycle-counter width
// used by both the debouncer and the pulse generator.
package key_pkg;

  localparam int CNT_W = 12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter with a registered one-cycle overflow pulse.
// Simultaneous inc and dec cancel; inc at full scale holds and flags ovf.
module sat_updown_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         ovf
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] count_q, count_d;
  logic         ovf_q, ovf_d;

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    if (inc && !dec) begin
      if (count_q == MAX) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + W'(1);
      end
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/key_pulse_gen.sv
// Turns single-cycle request strobes into ON_CYCLES-long output pulses, each
// followed by an OFF_CYCLES gap; requests arriving mid-pulse are queued.
module key_pulse_gen
  import key_pkg::*;
#(
  parameter int ON_CYCLES  = 600,
  parameter int OFF_CYCLES = 600,
  parameter int PEND_W     = 4
) (
  input  logic              mclk,
  input  logic              rst_n,
  input  logic              trig,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              done,
  output logic              drop
);

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             led_q, led_d;
  logic             done_q, done_d;

  logic gap_exit;
  logic has_pend;
  logic pend_inc;
  logic pend_dec;

  assign gap_exit = (state_q == S_GAP) && (cnt_q == OFF_LAST);
  assign has_pend = (pend_cnt != '0);

  // A trig on the exit cycle with nothing queued starts the next pulse
  // directly, so it must not also be counted as pending.
  assign pend_inc = trig && (state_q != S_IDLE) && !(gap_exit && !has_pend);
  assign pend_dec = gap_exit && has_pend;

  sat_updown_cnt #(
    .W(PEND_W)
  ) u_pend (
    .clk  (mclk),
    .rst_n(rst_n),
    .inc  (pend_inc),
    .dec  (pend_dec),
    .count(pend_cnt),
    .ovf  (drop)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d = S_ON;
          cnt_d   = '0;
          led_d   = 1'b1;
        end
      end
      S_ON: begin
        if (cnt_q == ON_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
          led_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (gap_exit) begin
          cnt_d = '0;
          if (has_pend || trig) begin
            state_d = S_ON;
            led_d   = 1'b1;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        led_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      led_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  assign led_out = led_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Bench for key_pulse_gen: two instances (4/3 and 1/1 timing) checked every
// cycle against a timeline model, plus directed literal expectations.
module tb_key_pulse_gen;

  localparam int NI   = 2;
  localparam int PMAX = 3;

  logic       mclk = 1'b0;
  logic       rst_n;
  logic       trig_a, trig_b;
  logic       led_a, busy_a, done_a, drop_a;
  logic       led_b, busy_b, done_b, drop_b;
  logic [1:0] pend_a, pend_b;

  always #5 mclk = ~mclk;

  key_pulse_gen #(.ON_CYCLES(4), .OFF_CYCLES(3), .PEND_W(2)) u_a (
    .mclk(mclk), .rst_n(rst_n), .trig(trig_a), .led_out(led_a),
    .busy(busy_a), .pend_cnt(pend_a), .done(done_a), .drop(drop_a)
  );

  key_pulse_gen #(.ON_CYCLES(1), .OFF_CYCLES(1), .PEND_W(2)) u_b (
    .mclk(mclk), .rst_n(rst_n), .trig(trig_b), .led_out(led_b),
    .busy(busy_b), .pend_cnt(pend_b), .done(done_b), .drop(drop_b)
  );

  // Timeline model: an active pulse is described by the cycle its output
  // first goes high; everything else follows from ON/OFF arithmetic.
  int m_on[NI]  = '{4, 1};
  int m_off[NI] = '{3, 1};
  bit m_active[NI];
  int m_start[NI];
  int m_pend[NI];
  bit m_done[NI];
  bit m_drop[NI];

  int cyc = 0;
  bit chk_en = 1'b0;
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
  endtask

  function automatic void step(int k, bit t, bit r, int c);
    m_done[k] = 1'b0;
    m_drop[k] = 1'b0;
    if (r) begin
      m_active[k] = 1'b0;
      m_pend[k]   = 0;
      return;
    end
    if (!m_active[k]) begin
      if (t) begin
        m_active[k] = 1'b1;
        m_start[k]  = c + 1;
      end
    end else if (c == m_start[k] + m_on[k] + m_off[k] - 1) begin
      if (m_pend[k] > 0) begin
        m_pend[k]--;
        m_start[k] = c + 1;
        if (t) m_pend[k]++;
      end else if (t) begin
        m_start[k] = c + 1;
      end else begin
        m_active[k] = 1'b0;
        m_done[k]   = 1'b1;
      end
    end else if (t) begin
      if (m_pend[k] == PMAX) m_drop[k] = 1'b1;
      else m_pend[k]++;
    end
  endfunction

  function automatic bit exp_led(int k);
    return m_active[k] && ((cyc - m_start[k]) < m_on[k]);
  endfunction

  always @(posedge mclk) begin
    step(0, trig_a, !rst_n, cyc);
    step(1, trig_b, !rst_n, cyc);
    cyc = cyc + 1;
  end

  always @(negedge mclk) begin
    if (chk_en) begin
      check("led_a",  led_a,  exp_led(0));
      check("busy_a", busy_a, m_active[0]);
      check("pend_a", pend_a, m_pend[0]);
      check("done_a", done_a, m_done[0]);
      check("drop_a", drop_a, m_drop[0]);
      check("led_b",  led_b,  exp_led(1));
      check("busy_b", busy_b, m_active[1]);
      check("pend_b", pend_b, m_pend[1]);
      check("done_b", done_b, m_done[1]);
      check("drop_b", drop_b, m_drop[1]);
    end
  end

  task automatic goto(input int n);
    while (cyc < n) @(negedge mclk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && (busy_a || busy_b); i++) @(negedge mclk);
    check("idle_wait_a", busy_a, 1'b0);
    check("idle_wait_b", busy_b, 1'b0);
    repeat (2) @(negedge mclk);
  endtask

  int b;
  int p;

  initial begin
    rst_n  = 1'b0;
    trig_a = 1'b0;
    trig_b = 1'b0;
    repeat (3) @(negedge mclk);
    rst_n = 1'b1;
    check("rst_led", led_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_pend", pend_a, 2'd0);
    check("rst_done", done_a, 1'b0);
    check("rst_drop", drop_a, 1'b0);
    chk_en = 1'b1;

    // Single request
    b = cyc + 2;
    goto(b); trig_a = 1'b1;
    goto(b + 1); trig_a = 1'b0;
    check("s1_led_rise", led_a, 1'b1);
    check("s1_busy", busy_a, 1'b1);
    goto(b + 4); check("s1_led_last", led_a, 1'b1);
    goto(b + 5); check("s1_led_fall", led_a, 1'b0);
    check("s1_busy_gap", busy_a, 1'b1);
    goto(b + 7); check("s1_busy_end", busy_a, 1'b1);
    check("s1_no_done", done_a, 1'b0);
    goto(b + 8); check("s1_done", done_a, 1'b1);
    check("s1_busy_fall", busy_a, 1'b0);
    goto(b + 9); check("s1_done_once", done_a, 1'b0);
    wait_idle();

    // Two requests, second queued
    b = cyc + 2;
    goto(b); trig_a = 1'b1;
    goto(b + 1); trig_a = 1'b0;
    goto(b + 2); trig_a = 1'b1;
    goto(b + 3); trig_a = 1'b0;
    check("s2_pend1", pend_a, 2'd1);
    goto(b + 8); check("s2_pend0", pend_a, 2'd0);
    check("s2_led2", led_a, 1'b1);
    goto(b + 15); check("s2_done", done_a, 1'b1);
    wait_idle();

    // Held trig: saturation and drops
    b = cyc + 2;
    goto(b); trig_a = 1'b1;
    goto(b + 4); check("s3_sat", pend_a, 2'd3);
    goto(b + 5); check("s3_drop", drop_a, 1'b1);
    goto(b + 7); check("s3_gap_low", led_a, 1'b0);
    goto(b + 8); check("s3_rise2", led_a, 1'b1);
    goto(b + 11); trig_a = 1'b0;
    wait_idle();

    // Trig exactly on the gap exit cycle
    b = cyc + 2;
    goto(b); trig_a = 1'b1;
    goto(b + 1); trig_a = 1'b0;
    goto(b + 7); trig_a = 1'b1;
    goto(b + 8); trig_a = 1'b0;
    check("s4_led", led_a, 1'b1);
    check("s4_no_done", done_a, 1'b0);
    check("s4_pend", pend_a, 2'd0);
    wait_idle();

    // Reset mid-pulse
    b = cyc + 2;
    goto(b); trig_a = 1'b1;
    goto(b + 1); trig_a = 1'b0;
    goto(b + 2); trig_a = 1'b1;
    goto(b + 3); trig_a = 1'b0; rst_n = 1'b0;
    goto(b + 4); rst_n = 1'b1;
    check("s5_led", led_a, 1'b0);
    check("s5_busy", busy_a, 1'b0);
    check("s5_pend", pend_a, 2'd0);
    goto(b + 5); check("s5_no_done", done_a, 1'b0);
    goto(b + 6); trig_a = 1'b1;
    goto(b + 7); trig_a = 1'b0;
    check("s5_restart", led_a, 1'b1);
    wait_idle();

    // ON=OFF=1 instance, two adjacent requests
    b = cyc + 2;
    goto(b); trig_b = 1'b1;
    goto(b + 1);
    check("sb_led1", led_b, 1'b1);
    goto(b + 2); trig_b = 1'b0;
    check("sb_gap", led_b, 1'b0);
    goto(b + 3); check("sb_led2", led_b, 1'b1);
    goto(b + 5); check("sb_done", done_b, 1'b1);
    wait_idle();

    // Randomized traffic with varying request density and rare resets
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 0) p = $urandom_range(2, 95);
      @(negedge mclk);
      trig_a = ($urandom_range(0, 99) < p);
      trig_b = ($urandom_range(0, 99) < p);
      rst_n  = ($urandom_range(0, 799) != 0);
    end
    @(negedge mclk);
    trig_a = 1'b0;
    trig_b = 1'b0;
    rst_n  = 1'b1;
    wait_idle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
